acc_display: RTL and testbench
==============================

# acc_display

Display stage that consumes the 16-bit accumulator register output and drives a 4-digit multiplexed common-anode seven-segment display. In decimal mode it converts the accumulator value to BCD with a sequential double-dabble engine. In hex mode it shows the raw nibbles. It sits directly downstream of the accumulator register, in parallel with the ALU B input.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit stays enabled; legal range ≥ 2.
- clk  in  1  system clock, rising-edge.
- clear_n  in  1  asynchronous, active-low reset.
- value  in  16  unsigned accumulator value to display.
- dec_mode  in  1  1 = decimal display, 0 = hex display.
- an  out  4  digit enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments, active-low; seg[0] = a … seg[6] = g.
- dp  out  1  decimal point, active-low.
- busy  out  1  high while a BCD conversion is in progress.

## Operation
- Snapshot register snap (16 b) and BCD register bcd (5 digits, 20 b).
- Converter FSM states:
  - IDLE: each cycle compares value with snap. On a difference: snap <= value, shift register <= value, working BCD <= 0, iteration counter <= 0, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every working-BCD nibble that is ≥ 5. Then shift {BCD, shift register} left by one. After the 16th iteration, go to DONE.
  - DONE: bcd <= working BCD, go to IDLE.
- While busy, value changes are ignored. IDLE re-compares on return, so the final value is always converted.
- Scanner: a 0..REFRESH_DIV-1 cycle counter. On wrap, digit index idx advances 0→1→2→3→0.
- Digit source:
  - hex mode: snap[4*idx+3 : 4*idx].
  - dec mode: bcd digit idx.
- Leading-zero blanking (dec mode only): digits above the most-significant nonzero BCD digit show all segments off (seg = 7'h7F). Digit 0 is never blanked.
- Decimal point:
  - dec mode: dp = 0 (lit) on idx 3 when bcd digit 4 ≠ 0, i.e. value > 9999. The display shows the low 4 decimal digits.
  - hex mode: dp = 1 (off) always.
- Segment codes (gfedcba, active-low), standard 0–F: 0 = 1000000, 1 = 1111001, 4 = 0011001, 8 = 0000000, B = 0000011, E = 0000110, F = 0001110.

## Timing
- Reset (clear_n low, asynchronous): FSM = IDLE, snap = 0, bcd = 0, busy = 0, counter = 0, idx = 0, an = 4'b1111, seg = 7'h7F, dp = 1.
- an, seg, dp are registered. They reflect the current idx/bcd/snap one cycle later. The first valid digit appears on the first edge after clear_n deasserts.
- Conversion latency: a difference detected at edge k gives busy = 1 from edge k through edge k+16. bcd is updated and busy = 0 at edge k+17, so busy is high for 17 cycles. Displayed outputs change at edge k+18.
- Hex mode shows the new snap from edge k+1 on.
- dec_mode toggles take effect on the next registered output update. No conversion is triggered.
- Reset asserted mid-conversion aborts immediately. bcd keeps its reset value of 0.
- Value unchanged: no conversion, busy stays 0.

## Structure
- Package acc_display_pkg:
  - converter state enum (IDLE, SHIFT, DONE)
  - NUM_DIGITS = 4, BCD_DIGITS = 5
  - SEG_BLANK = 7'h7F
  - the 16-entry segment constant table
- Sub-module bin2bcd_seq: the converter FSM. Ports: clk, clear_n, start, bin[15:0], busy, bcd[19:0].
- Top level holds the snapshot/compare logic, scanner, blanking, decoder and output registers.

## Test plan
- Reset, then dec_mode = 1, value = 0 → an = 1111, seg = 7F, dp = 1 during reset. After release, idx 0 shows seg = 1000000 and idx 1–3 are blanked.
- value = 1234, dec mode → busy high exactly 17 cycles. Digits 3..0 then show 1, 2, 3, 4; idx 0 shows seg = 0011001. dp = 1.
- value = 65535, dec mode → digits show 5, 5, 3, 5 and dp = 0 on idx 3 only.
- dec_mode = 0, value = 16'hBEEF → digits B, E, E, F (0000011, 0000110, 0000110, 0001110). No blanking, dp = 1.
- value = 100, then value = 200 five cycles into the conversion → bcd is 100 after the first conversion. A second conversion starts immediately, and bcd = 200 within 35 cycles of the first change.
- REFRESH_DIV = 4 → an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps. Asserting clear_n low mid-conversion → busy = 0 and all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/acc_display_pkg.sv
// Shared types and constants for the accumulator display stage:
// converter state encoding, digit counts and the seven-segment glyph table.
package acc_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_DIGITS = 5;
  localparam int VALUE_W    = 16;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order gfedcba, index = nibble value 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits,
// one bit per cycle. busy covers the SHIFT and DONE states; bcd holds the
// last completed result and only changes when a conversion finishes.
module bin2bcd_seq
  import acc_display_pkg::*;
(
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd
);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj;
  logic [3:0]         iter_q, iter_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  // Add-3 correction on every working nibble that is 5 or more.
  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                   : work_q[4*i +: 4];
    end
  end

  // Converter next-state: load on start, 16 correct-and-shift steps, publish.
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          shift_d = bin;
          work_d  = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        {work_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Converter state register; asynchronous clear aborts any conversion.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/acc_display.sv
// Four-digit multiplexed common-anode display of the accumulator value.
// Decimal mode shows the converted BCD with leading-zero blanking and a
// decimal point on the leftmost digit when the value exceeds 9999; hex mode
// shows the snapshot nibbles directly. an/seg/dp are registered.
module acc_display
  import acc_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic [15:0] value,
  input  logic        dec_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [VALUE_W-1:0] snap_q, snap_d;
  logic               start;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         digit;
  logic [BCD_W-1:0]   bcd_upper;
  logic               blank;

  // A new conversion is requested only when idle and the input has moved.
  assign start = !busy && (value != snap_q);

  bin2bcd_seq u_conv (
    .clk     (clk),
    .clear_n (clear_n),
    .start   (start),
    .bin     (value),
    .busy    (busy),
    .bcd     (bcd)
  );

  // Snapshot follows the input at the same edge the conversion starts.
  always_comb begin
    snap_d = start ? value : snap_q;
  end

  // Refresh scanner: hold each digit REFRESH_DIV cycles, then advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Digit selection, leading-zero blanking, glyph and decimal point.
  always_comb begin
    bcd_upper = bcd >> {idx_q, 2'b00};
    digit     = dec_mode ? bcd[{idx_q, 2'b00} +: 4] : snap_q[{idx_q, 2'b00} +: 4];
    blank     = dec_mode && (idx_q != '0) && (bcd_upper == '0);
    seg_d     = blank ? SEG_BLANK : seg_decode(digit);
    dp_d      = !(dec_mode && (idx_q == IDX_LAST) && (bcd[BCD_W-1 -: 4] != 4'd0));
    an_d      = ~(4'b0001 << idx_q);
  end

  // Snapshot, scanner and output registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      snap_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_acc_display.sv
// Self-checking bench for acc_display. A value-level model (integer BCD
// value, cycle-count scanner, busy countdown) predicts an/seg/dp/busy every
// cycle; directed steps add literal glyph expectations from the spec.
module tb_acc_display;

  localparam int DIV = 4;

  logic        clk      = 1'b0;
  logic        clear_n  = 1'b1;
  logic        dec_mode = 1'b1;
  logic [15:0] value    = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  acc_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .value    (value),
    .dec_mode (dec_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Glyphs 0..F, gfedcba active-low.
  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_edges     = 0;
  logic [15:0] m_snap      = 16'd0;
  int          m_bcd_val   = 0;
  int          m_pending   = 0;
  int          m_busy_left = 0;
  logic [3:0]  e_an        = 4'b1111;
  logic [6:0]  e_seg       = 7'h7F;
  logic        e_dp        = 1'b1;
  logic        e_busy      = 1'b0;

  always @(posedge clk or negedge clear_n) begin
    int idx;
    int dig;
    if (!clear_n) begin
      m_edges = 0; m_snap = 16'd0; m_bcd_val = 0; m_pending = 0; m_busy_left = 0;
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0;
    end else begin
      idx  = (m_edges / DIV) % 4;
      e_an = ~(4'b0001 << idx);
      if (dec_mode) begin
        dig   = (m_bcd_val / pow10(idx)) % 10;
        e_seg = (idx != 0 && m_bcd_val < pow10(idx)) ? 7'h7F : seg_ref[dig];
        e_dp  = !(idx == 3 && m_bcd_val > 9999);
      end else begin
        dig   = (int'(m_snap) >> (4 * idx)) & 15;
        e_seg = seg_ref[dig];
        e_dp  = 1'b1;
      end
      m_edges++;
      if (m_busy_left == 0) begin
        if (value != m_snap) begin
          m_snap      = value;
          m_pending   = int'(value);
          m_busy_left = 17;
        end
      end else begin
        m_busy_left--;
        if (m_busy_left == 0) m_bcd_val = m_pending;
      end
      e_busy = (m_busy_left != 0);
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("an",   {28'd0, an},   {28'd0, e_an});
    check("seg",  {25'd0, seg},  {25'd0, e_seg});
    check("dp",   {31'd0, dp},   {31'd0, e_dp});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
  end

  // ---------------- directed helpers ----------------
  task automatic wait_an(input logic [3:0] pat);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an == pat) return;
    end
    check("wait_an_timeout", {28'd0, an}, {28'd0, pat});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic expect_digit(input string name, input logic [3:0] pat,
                              input logic [6:0] s, input logic d);
    wait_an(pat);
    check({name, "_seg"}, {25'd0, seg}, {25'd0, s});
    check({name, "_dp"},  {31'd0, dp},  {31'd0, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;

    // Reset with dec_mode=1, value=0.
    #1 clear_n = 1'b0;
    @(negedge clk);
    check("rst_an",   {28'd0, an},   32'hF);
    check("rst_seg",  {25'd0, seg},  32'h7F);
    check("rst_dp",   {31'd0, dp},   32'h1);
    check("rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check("first_an",  {28'd0, an},  32'hE);
    check("first_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    expect_digit("zero_d1", 4'b1101, 7'h7F, 1'b1);
    expect_digit("zero_d2", 4'b1011, 7'h7F, 1'b1);
    expect_digit("zero_d3", 4'b0111, 7'h7F, 1'b1);

    // 1234 in decimal.
    value = 16'd1234;
    count_busy(n);
    check("busy_len_1234", n, 17);
    expect_digit("d1234_0", 4'b1110, 7'b0011001, 1'b1);
    expect_digit("d1234_1", 4'b1101, 7'b0110000, 1'b1);
    expect_digit("d1234_2", 4'b1011, 7'b0100100, 1'b1);
    expect_digit("d1234_3", 4'b0111, 7'b1111001, 1'b1);

    // 65535: low four digits 5535, dp lit on the leftmost digit only.
    value = 16'd65535;
    count_busy(n);
    check("busy_len_65535", n, 17);
    expect_digit("d65535_3", 4'b0111, 7'b0010010, 1'b0);
    expect_digit("d65535_0", 4'b1110, 7'b0010010, 1'b1);
    expect_digit("d65535_1", 4'b1101, 7'b0110000, 1'b1);
    expect_digit("d65535_2", 4'b1011, 7'b0010010, 1'b1);

    // Hex mode, BEEF: shown from the edge after the snapshot.
    dec_mode = 1'b0;
    value    = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    expect_digit("hex_3", 4'b0111, 7'b0000011, 1'b1);
    expect_digit("hex_2", 4'b1011, 7'b0000110, 1'b1);
    expect_digit("hex_1", 4'b1101, 7'b0000110, 1'b1);
    expect_digit("hex_0", 4'b1110, 7'b0001110, 1'b1);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("hex_conv_done", {31'd0, busy}, 32'h0);

    // Change during conversion: 100 completes, then 200 follows at once.
    dec_mode = 1'b1;
    value    = 16'd100;
    @(negedge clk);
    n = 0;
    check("b100_busy", {31'd0, busy}, 32'h1);
    repeat (5) begin @(negedge clk); n++; end
    value = 16'd200;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("b100_done_at", n, 17);
    check("b100_bcd", {12'd0, dut.bcd}, 32'h00100);
    while (dut.bcd != 20'h00200 && n < 40) begin @(negedge clk); n++; end
    check("b200_bcd", {12'd0, dut.bcd}, 32'h00200);
    check("b200_within_35", {31'd0, (n <= 35)}, 32'h1);

    // Reset asserted mid-conversion: immediate abort.
    value = 16'd4321;
    repeat (6) @(negedge clk);
    check("abort_was_busy", {31'd0, busy}, 32'h1);
    #2 clear_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_an",   {28'd0, an},   32'hF);
    check("abort_seg",  {25'd0, seg},  32'h7F);
    check("abort_dp",   {31'd0, dp},   32'h1);
    check("abort_bcd",  {12'd0, dut.bcd}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;

    // Scan order after release: each enable held DIV cycles, then wraps.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("scan_an", {28'd0, an}, {28'd0, ~(4'b0001 << ((i / DIV) % 4))});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
